ctrl_cmd_serializer: RTL and testbench
======================================

Name: ctrl_cmd_serializer

Overview:
- Host-side command encoder for the control-unit byte protocol.
- Accepts one decoded command per request (opcode plus payload fields) and emits it as a byte stream: opcode first, then payload MSB-first.
- Paces each byte with the consumer's one-cycle `next` acknowledge.
- Sits between the MCU/SPI bridge (or a testbench driver) and the control unit's in_byte/in_valid/next port.

Parameters:
- N_BLOCKS, 256: block count. BLOCK_BYTES = 2 if N_BLOCKS > 256, else 1.
- DATA_WIDTH, 16: register data width, 16 or 24. DATA_BYTES = 3 if 24, else 2.
- GAP_CYCLES, 2: idle cycles with out_valid low after each ack, minimum 1.
- TIMEOUT_CYCLES, 4096: cycles to wait for an ack before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only; a command is accepted when cmd_valid && cmd_ready
- cmd_opcode  in  8  COMMAND_* value from controller.vh
- cmd_block  in  max(1,clog2(N_BLOCKS))  block target
- cmd_word  in  32  instruction word, or register/gain data in the low DATA_WIDTH bits
- cmd_delay_size  in  24  delay allocation size
- cmd_init_delay  in  24  initial delay
- out_byte  out  8  byte to consumer (drives in_byte)
- out_valid  out  1  byte valid (drives in_valid)
- byte_ack  in  1  consumer `next` pulse
- busy  out  1  high when not in IDLE
- cmd_done  out  1  one-cycle pulse when the last byte is acked
- cmd_error  out  1  one-cycle pulse when an unknown opcode is rejected
- cmd_timeout  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset values: out_valid=0, out_byte=0, cmd_ready=1, busy=0, all pulses 0, state IDLE, counters 0.
- Accept: on a cycle with cmd_valid && cmd_ready, latch all cmd_* fields into a 6-byte shift buffer plus the opcode.
  - Payload length N: WRITE_BLOCK_INSTR → BLOCK_BYTES+4.
  - WRITE/UPDATE_BLOCK_REG_0/1 → BLOCK_BYTES+DATA_BYTES.
  - ALLOC_DELAY → 6.
  - SET_INPUT_GAIN / SET_OUTPUT_GAIN → DATA_BYTES.
  - SWAP_PIPELINES, RESET_PIPELINE, COMMIT_REG_UPDATES → 0.
- Unknown opcode: pulse cmd_error in the cycle after accept, send nothing, stay IDLE.
- Payload order, all MSB-first:
  - INSTR: block (hi byte first if 2 bytes), then cmd_word[31:24] … [7:0].
  - REG: block, then data. The data field is the DATA_BYTES*8 low bits of cmd_word.
  - ALLOC: size[23:16], [15:8], [7:0], then init[23:16], [15:8], [7:0].
  - GAIN: data only.
- States:
  - IDLE: on accept of a known opcode → SEND with out_byte=opcode and out_valid=1 in the next cycle. Latency from accept to first valid byte is 1 cycle.
  - SEND: hold out_byte stable and out_valid high until byte_ack. On ack, drop out_valid next cycle. If bytes remain → GAP; else pulse cmd_done → IDLE.
  - GAP: out_valid=0 for GAP_CYCLES cycles, load the next payload byte, → SEND.
- byte_ack outside SEND is ignored.
- Timeout counter is cleared on each entry to SEND and counts while in SEND. When it reaches TIMEOUT_CYCLES:
  - drop out_valid,
  - pulse cmd_timeout,
  - discard remaining bytes,
  - → IDLE.
  - An ack arriving in the same cycle as expiry wins; no timeout is signalled.
- cmd_ready is combinational from state (IDLE). A new command may be accepted in the cycle cmd_done pulses, because the state is IDLE then.
- Reset mid-command aborts immediately to reset values with no pulses. Partial streams are not resumed.
- out_byte holds its last value when out_valid=0.

Test Plan:
- N_BLOCKS=256, WRITE_BLOCK_INSTR, block 0x12, word 0xDEADBEEF, ack 3 cycles after each valid → bytes opcode, 12, DE, AD, BE, EF. GAP_CYCLES low cycles between bytes. cmd_done once, after the 6th ack.
- N_BLOCKS=512, WRITE_BLOCK_REG_1, block 0x1A5, word 0x00001234 → opcode, 01, A5, 12, 34. busy high throughout. cmd_ready low until done.
- ALLOC_DELAY, size 0x012345, init 0x00ABCD → opcode, 01, 23, 45, 00, AB, CD.
- SWAP_PIPELINES → single opcode byte, cmd_done on its ack. Opcode 0xFF (undefined) → cmd_error pulse, out_valid never rises.
- SET_INPUT_GAIN with no ack, TIMEOUT_CYCLES=16 → out_valid high for exactly 16 cycles, cmd_timeout pulse, return to IDLE. Repeat with ack on cycle 16 → no timeout, stream continues.
- Reset asserted during the 3rd byte of an INSTR command → next cycle out_valid=0 and cmd_ready=1. A following command streams correctly from its opcode.

Source files
------------

// File: rtl/ctrl_cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_cmd_serializer
// Function : Encodes one decoded host command into an ack-paced byte stream
//            (opcode first, payload MSB-first) for the control unit.
// Revision : 1.0
// ============================================================================
module ctrl_cmd_serializer #(
    parameter int N_BLOCKS       = 256,
    parameter int DATA_WIDTH     = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int c_BLK_W       = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_opcode,
    input  logic [c_BLK_W-1:0] cmd_block,
    input  logic [31:0]        cmd_word,
    input  logic [23:0]        cmd_delay_size,
    input  logic [23:0]        cmd_init_delay,
    output logic [7:0]         out_byte,
    output logic               out_valid,
    input  logic               byte_ack,
    output logic               busy,
    output logic               cmd_done,
    output logic               cmd_error,
    output logic               cmd_timeout
);

    localparam int c_BLOCK_BYTES = (N_BLOCKS > 256) ? 2 : 1;
    localparam int c_DATA_BYTES  = (DATA_WIDTH == 24) ? 3 : 2;
    localparam int c_BW          = 8 * c_BLOCK_BYTES;
    localparam int c_DW          = 8 * c_DATA_BYTES;
    localparam int c_TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_GAP_W       = $clog2(GAP_CYCLES + 1);

    localparam logic [7:0] c_OP_WRITE_BLOCK_INSTR  = 8'h01;
    localparam logic [7:0] c_OP_WRITE_BLOCK_REG_0  = 8'h02;
    localparam logic [7:0] c_OP_WRITE_BLOCK_REG_1  = 8'h03;
    localparam logic [7:0] c_OP_UPDATE_BLOCK_REG_0 = 8'h04;
    localparam logic [7:0] c_OP_UPDATE_BLOCK_REG_1 = 8'h05;
    localparam logic [7:0] c_OP_ALLOC_DELAY        = 8'h06;
    localparam logic [7:0] c_OP_SET_INPUT_GAIN     = 8'h07;
    localparam logic [7:0] c_OP_SET_OUTPUT_GAIN    = 8'h08;
    localparam logic [7:0] c_OP_SWAP_PIPELINES     = 8'h09;
    localparam logic [7:0] c_OP_RESET_PIPELINE     = 8'h0A;
    localparam logic [7:0] c_OP_COMMIT_REG_UPDATES = 8'h0B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [47:0]        r_buf;
    logic [2:0]         r_remain;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [7:0]         r_out_byte;
    logic               r_out_valid;
    logic               r_done;
    logic               r_error;
    logic               r_timeout;

    logic               w_accept;
    logic               w_known;
    logic [2:0]         w_len;
    logic [47:0]        w_payload;
    logic [15:0]        w_blk16;
    logic [47:0]        w_data_wide;
    logic               w_last;
    logic               w_gap_end;
    logic               w_tmo_expire;

    assign w_blk16      = 16'(cmd_block);
    assign w_data_wide  = 48'(cmd_word[c_DW-1:0]);
    assign w_accept     = cmd_valid && (r_state == S_IDLE);
    assign w_last       = (r_remain == 3'd0);
    assign w_gap_end    = (r_gap_cnt == c_GAP_W'(GAP_CYCLES - 1));
    assign w_tmo_expire = (r_state == S_SEND) && !byte_ack
                          && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    // Payload is left-aligned in the shift buffer so every byte leaves from [47:40].
    always_comb begin
        w_known   = 1'b1;
        w_len     = 3'd0;
        w_payload = 48'h0;
        case (cmd_opcode)
            c_OP_WRITE_BLOCK_INSTR: begin
                w_len     = 3'(c_BLOCK_BYTES + 4);
                w_payload = ((48'(w_blk16) << 32) | 48'(cmd_word)) << (8 * (2 - c_BLOCK_BYTES));
            end
            c_OP_WRITE_BLOCK_REG_0, c_OP_WRITE_BLOCK_REG_1,
            c_OP_UPDATE_BLOCK_REG_0, c_OP_UPDATE_BLOCK_REG_1: begin
                w_len     = 3'(c_BLOCK_BYTES + c_DATA_BYTES);
                w_payload = ((48'(w_blk16) << c_DW) | w_data_wide) << (48 - c_BW - c_DW);
            end
            c_OP_ALLOC_DELAY: begin
                w_len     = 3'd6;
                w_payload = {cmd_delay_size, cmd_init_delay};
            end
            c_OP_SET_INPUT_GAIN, c_OP_SET_OUTPUT_GAIN: begin
                w_len     = 3'(c_DATA_BYTES);
                w_payload = w_data_wide << (48 - c_DW);
            end
            c_OP_SWAP_PIPELINES, c_OP_RESET_PIPELINE, c_OP_COMMIT_REG_UPDATES: begin
                w_len = 3'd0;
            end
            default: w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_known) w_state_nxt = S_SEND;
            S_SEND: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (byte_ack)          w_state_nxt = w_last ? S_IDLE : S_GAP;
                else if (w_tmo_expire) w_state_nxt = S_IDLE;
            end
            S_GAP:  if (w_gap_end) w_state_nxt = S_SEND;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_buf       <= 48'h0;
            r_remain    <= 3'd0;
            r_tmo_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_out_byte  <= 8'h00;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_known) begin
                            r_buf       <= w_payload;
                            r_remain    <= w_len;
                            r_out_byte  <= cmd_opcode;
                            r_out_valid <= 1'b1;
                            r_tmo_cnt   <= '0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (byte_ack) begin
                        r_out_valid <= 1'b0;
                        r_gap_cnt   <= '0;
                        r_done      <= w_last;
                    end else if (w_tmo_expire) begin
                        r_out_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_remain    <= 3'd0;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                    if (w_gap_end) begin
                        r_out_byte  <= r_buf[47:40];
                        r_buf       <= r_buf << 8;
                        r_remain    <= r_remain - 1'b1;
                        r_out_valid <= 1'b1;
                        r_tmo_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign out_byte    = r_out_byte;
    assign out_valid   = r_out_valid;
    assign cmd_done    = r_done;
    assign cmd_error   = r_error;
    assign cmd_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_cmd_serializer
// Function : Self-checking bench for ctrl_cmd_serializer (two parameter sets).
// Revision : 1.0
// ============================================================================
module tb_ctrl_cmd_serializer;

    localparam logic [7:0] OP_INSTR   = 8'h01;
    localparam logic [7:0] OP_REG0    = 8'h02;
    localparam logic [7:0] OP_REG1    = 8'h03;
    localparam logic [7:0] OP_UPD0    = 8'h04;
    localparam logic [7:0] OP_UPD1    = 8'h05;
    localparam logic [7:0] OP_ALLOC   = 8'h06;
    localparam logic [7:0] OP_GAIN_IN = 8'h07;
    localparam logic [7:0] OP_GAIN_OU = 8'h08;
    localparam logic [7:0] OP_SWAP    = 8'h09;
    localparam logic [7:0] OP_RSTP    = 8'h0A;
    localparam logic [7:0] OP_COMMIT  = 8'h0B;
    localparam int GAP_A = 2;
    localparam int GAP_B = 1;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel, cmd_valid, byte_ack;
    logic [7:0]  cmd_opcode;
    logic [8:0]  cmd_block;
    logic [31:0] cmd_word;
    logic [23:0] cmd_delay_size, cmd_init_delay;

    logic a_rdy, a_ov, a_busy, a_done, a_err, a_tmo;
    logic b_rdy, b_ov, b_busy, b_done, b_err, b_tmo;
    logic [7:0] a_ob, b_ob;
    logic rdy, ov, busy, done, err, tmo;
    logic [7:0] ob;

    ctrl_cmd_serializer #(.N_BLOCKS(256), .DATA_WIDTH(16), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TMO)) u_dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_rdy),
        .cmd_opcode(cmd_opcode), .cmd_block(cmd_block[7:0]), .cmd_word(cmd_word),
        .cmd_delay_size(cmd_delay_size), .cmd_init_delay(cmd_init_delay),
        .out_byte(a_ob), .out_valid(a_ov), .byte_ack(byte_ack & ~sel),
        .busy(a_busy), .cmd_done(a_done), .cmd_error(a_err), .cmd_timeout(a_tmo)
    );

    ctrl_cmd_serializer #(.N_BLOCKS(512), .DATA_WIDTH(16), .GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(TMO)) u_dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid & sel), .cmd_ready(b_rdy),
        .cmd_opcode(cmd_opcode), .cmd_block(cmd_block), .cmd_word(cmd_word),
        .cmd_delay_size(cmd_delay_size), .cmd_init_delay(cmd_init_delay),
        .out_byte(b_ob), .out_valid(b_ov), .byte_ack(byte_ack & sel),
        .busy(b_busy), .cmd_done(b_done), .cmd_error(b_err), .cmd_timeout(b_tmo)
    );

    assign rdy  = sel ? b_rdy  : a_rdy;
    assign ov   = sel ? b_ov   : a_ov;
    assign busy = sel ? b_busy : a_busy;
    assign done = sel ? b_done : a_done;
    assign err  = sel ? b_err  : a_err;
    assign tmo  = sel ? b_tmo  : a_tmo;
    assign ob   = sel ? b_ob   : a_ob;

    int n_checks = 0;
    int n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the byte list a command should produce, built field by field.
    logic [7:0] mq[$];

    function automatic void push_field(input logic [31:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) mq.push_back(8'(v >> (8 * k)));
    endfunction

    function automatic void model(input logic s, input logic [7:0] op, input logic [8:0] blk,
                                  input logic [31:0] word, input logic [23:0] sz, input logic [23:0] ini,
                                  output int n, output logic [55:0] bytes);
        int bb;
        logic [31:0] blk_v;
        bb    = s ? 2 : 1;
        blk_v = s ? {23'b0, blk} : {24'b0, blk[7:0]};
        mq.delete();
        mq.push_back(op);
        case (op)
            OP_INSTR:                          begin push_field(blk_v, bb); push_field(word, 4); end
            OP_REG0, OP_REG1, OP_UPD0, OP_UPD1: begin push_field(blk_v, bb); push_field(word, 2); end
            OP_ALLOC:                          begin push_field({8'h0, sz}, 3); push_field({8'h0, ini}, 3); end
            OP_GAIN_IN, OP_GAIN_OU:            push_field(word, 2);
            OP_SWAP, OP_RSTP, OP_COMMIT:       ;
            default:                           mq.delete();
        endcase
        n     = mq.size();
        bytes = 56'h0;
        for (int i = 0; i < n; i++) bytes[55 - 8 * i -: 8] = mq[i];
    endfunction

    // Issues one command and follows its whole stream; returns in the done (or error) cycle.
    task automatic run_cmd(input logic s, input logic [7:0] op, input logic [8:0] blk,
                           input logic [31:0] word, input logic [23:0] sz, input logic [23:0] ini,
                           input int ack_dly, input int exp_n, input logic [55:0] exp_bytes);
        int gap;
        logic [7:0] eb;
        gap            = s ? GAP_B : GAP_A;
        sel            = s;
        cmd_opcode     = op;
        cmd_block      = blk;
        cmd_word       = word;
        cmd_delay_size = sz;
        cmd_init_delay = ini;
        cmd_valid      = 1'b1;
        chk("accept_ready", 32'(rdy), 32'd1);
        tick();
        cmd_valid = 1'b0;
        if (exp_n == 0) begin
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_no_valid", 32'(ov), 32'd0);
            chk("err_ready", 32'(rdy), 32'd1);
            tick();
            chk("err_once", 32'(err), 32'd0);
            chk("err_still_no_valid", 32'(ov), 32'd0);
            return;
        end
        for (int i = 0; i < exp_n; i++) begin
            eb = exp_bytes[55 - 8 * i -: 8];
            chk("byte_valid", 32'(ov), 32'd1);
            chk("byte_value", 32'(ob), 32'(eb));
            chk("busy_high", 32'(busy), 32'd1);
            chk("ready_low", 32'(rdy), 32'd0);
            for (int d = 0; d < ack_dly; d++) begin
                tick();
                chk("hold_valid", 32'(ov), 32'd1);
                chk("hold_byte", 32'(ob), 32'(eb));
            end
            byte_ack = 1'b1;
            tick();
            byte_ack = 1'b0;
            chk("drop_after_ack", 32'(ov), 32'd0);
            chk("byte_held_low", 32'(ob), 32'(eb));
            chk("no_timeout", 32'(tmo), 32'd0);
            if (i == exp_n - 1) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_ready", 32'(rdy), 32'd1);
                chk("done_not_busy", 32'(busy), 32'd0);
            end else begin
                chk("no_early_done", 32'(done), 32'd0);
                for (int g = 1; g < gap; g++) begin
                    tick();
                    chk("gap_low", 32'(ov), 32'd0);
                    chk("gap_busy", 32'(busy), 32'd1);
                end
                tick();
            end
        end
    endtask

    typedef struct {
        logic        s;
        logic [7:0]  op;
        logic [8:0]  blk;
        logic [31:0] word;
        logic [23:0] sz;
        logic [23:0] ini;
        int          ack;
        int          n;
        logic [55:0] exp;
    } vec_t;

    vec_t vecs[13];
    logic [7:0] known_ops[11];

    initial begin
        int hi;
        int n;
        logic [55:0] eb;
        logic s;
        logic [7:0] op;
        int r;

        vecs[0]  = '{1'b0, OP_INSTR,   9'h012, 32'hDEADBEEF, 24'h0,      24'h0,      3, 6, 56'h01_12_DE_AD_BE_EF_00};
        vecs[1]  = '{1'b1, OP_REG1,    9'h1A5, 32'h00001234, 24'h0,      24'h0,      2, 5, 56'h03_01_A5_12_34_00_00};
        vecs[2]  = '{1'b0, OP_ALLOC,   9'h000, 32'h0,        24'h012345, 24'h00ABCD, 0, 7, 56'h06_01_23_45_00_AB_CD};
        vecs[3]  = '{1'b0, OP_SWAP,    9'h000, 32'h0,        24'h0,      24'h0,      1, 1, 56'h09_00_00_00_00_00_00};
        vecs[4]  = '{1'b0, 8'hFF,      9'h000, 32'h0,        24'h0,      24'h0,      0, 0, 56'h0};
        vecs[5]  = '{1'b0, OP_GAIN_IN, 9'h000, 32'hCAFE5A5A, 24'h0,      24'h0,      2, 3, 56'h07_5A_5A_00_00_00_00};
        vecs[6]  = '{1'b1, OP_INSTR,   9'h101, 32'h01020304, 24'h0,      24'h0,      1, 7, 56'h01_01_01_01_02_03_04};
        vecs[7]  = '{1'b1, OP_ALLOC,   9'h000, 32'h0,        24'hFFFFFF, 24'h000001, 4, 7, 56'h06_FF_FF_FF_00_00_01};
        vecs[8]  = '{1'b0, OP_REG0,    9'h0FF, 32'hABCD1234, 24'h0,      24'h0,      0, 4, 56'h02_FF_12_34_00_00_00};
        vecs[9]  = '{1'b1, OP_GAIN_OU, 9'h000, 32'h00009876, 24'h0,      24'h0,      0, 3, 56'h08_98_76_00_00_00_00};
        vecs[10] = '{1'b0, OP_COMMIT,  9'h000, 32'h0,        24'h0,      24'h0,      2, 1, 56'h0B_00_00_00_00_00_00};
        vecs[11] = '{1'b1, 8'h00,      9'h000, 32'h0,        24'h0,      24'h0,      0, 0, 56'h0};
        vecs[12] = '{1'b1, OP_UPD1,    9'h000, 32'hFFFF0000, 24'h0,      24'h0,      1, 5, 56'h05_00_00_00_00_00_00};
        known_ops = '{OP_INSTR, OP_REG0, OP_REG1, OP_UPD0, OP_UPD1, OP_ALLOC,
                      OP_GAIN_IN, OP_GAIN_OU, OP_SWAP, OP_RSTP, OP_COMMIT};

        reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; byte_ack = 1'b0;
        cmd_opcode = 8'h0; cmd_block = 9'h0; cmd_word = 32'h0;
        cmd_delay_size = 24'h0; cmd_init_delay = 24'h0;
        repeat (3) tick();
        reset = 1'b0;

        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            chk("rst_out_valid", 32'(ov), 32'd0);
            chk("rst_out_byte", 32'(ob), 32'd0);
            chk("rst_ready", 32'(rdy), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_pulses", {29'b0, done, err, tmo}, 32'd0);
        end

        // Ack while idle must have no effect.
        sel = 1'b0;
        byte_ack = 1'b1;
        tick(); tick();
        byte_ack = 1'b0;
        chk("idle_ack_valid", 32'(ov), 32'd0);
        chk("idle_ack_busy", 32'(busy), 32'd0);
        chk("idle_ack_done", 32'(done), 32'd0);

        for (int i = 0; i < 13; i++)
            run_cmd(vecs[i].s, vecs[i].op, vecs[i].blk, vecs[i].word, vecs[i].sz, vecs[i].ini,
                    vecs[i].ack, vecs[i].n, vecs[i].exp);

        // No ack at all: valid for exactly TMO cycles, then timeout pulse.
        tick();
        sel = 1'b0; cmd_opcode = OP_GAIN_IN; cmd_word = 32'h00001234; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        hi = 0;
        for (int c = 0; c < 40 && ov; c++) begin hi++; tick(); end
        chk("timeout_valid_cycles", 32'(hi), 32'(TMO));
        chk("timeout_pulse", 32'(tmo), 32'd1);
        chk("timeout_ready", 32'(rdy), 32'd1);
        chk("timeout_byte_held", 32'(ob), 32'(OP_GAIN_IN));
        tick();
        chk("timeout_once", 32'(tmo), 32'd0);
        chk("timeout_no_done", 32'(done), 32'd0);

        // Ack in the last allowed cycle beats the timeout.
        model(1'b0, OP_GAIN_IN, 9'h0, 32'h0000ABCD, 24'h0, 24'h0, n, eb);
        run_cmd(1'b0, OP_GAIN_IN, 9'h0, 32'h0000ABCD, 24'h0, 24'h0, TMO - 1, n, eb);

        // Reset while the third INSTR byte is on the bus.
        tick();
        sel = 1'b0; cmd_opcode = OP_INSTR; cmd_block = 9'h012; cmd_word = 32'hDEADBEEF; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            byte_ack = 1'b1;
            tick();
            byte_ack = 1'b0;
            for (int w = 0; w < 10 && !ov; w++) tick();
        end
        chk("rst_mid_third_valid", 32'(ov), 32'd1);
        chk("rst_mid_third_byte", 32'(ob), 32'hDE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_valid", 32'(ov), 32'd0);
        chk("rst_mid_ready", 32'(rdy), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_byte", 32'(ob), 32'd0);
        chk("rst_mid_pulses", {29'b0, done, err, tmo}, 32'd0);
        run_cmd(vecs[0].s, vecs[0].op, vecs[0].blk, vecs[0].word, vecs[0].sz, vecs[0].ini,
                vecs[0].ack, vecs[0].n, vecs[0].exp);

        // Randomized commands against the reference model, issued back-to-back.
        for (int t = 0; t < 60; t++) begin
            s  = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 12));
            op = (r < 11) ? known_ops[r] : 8'($urandom_range(12, 255));
            cmd_block = 9'($urandom) & (s ? 9'h1FF : 9'h0FF);
            cmd_word  = $urandom;
            cmd_delay_size = 24'($urandom);
            cmd_init_delay = 24'($urandom);
            model(s, op, cmd_block, cmd_word, cmd_delay_size, cmd_init_delay, n, eb);
            run_cmd(s, op, cmd_block, cmd_word, cmd_delay_size, cmd_init_delay,
                    int'($urandom_range(0, 6)), n, eb);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
